// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch                                                  |
// | Description : Instruction fetch unit. Issues word reads to a synchronous   |
// |               (one-cycle latency) read-only instruction memory, buffers    |
// |               returned instructions in a 2-entry FIFO and presents them    |
// |               to decode through a valid/ready handshake. Supports          |
// |               control-flow redirects that flush all buffered and           |
// |               in-flight work.                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   ADDR_W   word-address width of instruction memory (default 8)           |
// |   DATA_W   instruction width (default 32)                                  |
// |   RESET_PC fetch word address after reset (default 0)                      |
// | Ports                                                                      |
// |   clk_i            in   1       clock, all state rises on posedge          |
// |   areset_i         in   1       asynchronous active-high reset             |
// |   enable_i         in   1       permit issuing new fetches                 |
// |   redirect_valid_i in   1       control-flow redirect request              |
// |   redirect_pc_i    in   ADDR_W  redirect target word address               |
// |   mem_rw_en_o      out  1       memory write enable, always 0              |
// |   mem_addr_o       out  ADDR_W  memory read address                        |
// |   mem_data_o       out  DATA_W  memory write data, always 0                |
// |   mem_data_i       in   DATA_W  memory read data (cycle after address)     |
// |   instr_valid_o    out  1       instruction available to decode            |
// |   instr_ready_i    in   1       decode accepts instruction                 |
// |   instr_o          out  DATA_W  fetched instruction                        |
// |   pc_o             out  ADDR_W  word address of instr_o                    |
// |   fetch_count_o    out  32      completed handshakes (IF_PERF_CNT_EN only) |
// | Build option                                                               |
// |   IF_PERF_CNT_EN   define to add the fetch_count_o performance counter     |
// +----------------------------------------------------------------------------+
module instr_fetch #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk_i,
  input  logic              areset_i,
  input  logic              enable_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_rw_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count_o
`endif
);

  localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] c_pc_step  = ADDR_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  // Fetch-side state
  logic [ADDR_W-1:0] r_fetch_pc;     // next address to issue
  logic [ADDR_W-1:0] r_last_addr;    // address of the most recent issue
  logic              r_inflight;     // a read response arrives this cycle
  logic [ADDR_W-1:0] r_inflight_pc;  // address belonging to that response

  // Two-entry instruction buffer
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [ADDR_W-1:0] r_fifo_pc   [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [2:0]        w_load;
  logic [2:0]        w_limit;

  // Handshake with decode and capture of the returning response. A redirect
  // in the same cycle wins over the capture, so the stale response is dropped.
  assign w_pop  = (r_count != 2'd0) && instr_ready_i;
  assign w_push = r_inflight && !redirect_valid_i;

  // Occupancy check "count + inflight - pop < 2" rearranged as
  // "count + inflight < 2 + pop" so the arithmetic never goes negative.
  // A fetch issued now lands in the FIFO at the end of the next cycle, so this
  // guarantees the buffer never has to hold a third entry.
  assign w_load  = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_limit = 3'd2 + {2'b00, w_pop};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and issue decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (!enable_i) begin
          w_state_next = IDLE;
        end
        // A redirect suppresses the issue; the new target goes out next cycle.
        if (!redirect_valid_i && (w_load < w_limit)) begin
          w_issue = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch PC, held address and in-flight tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_fetch_pc    <= c_reset_pc;
      r_last_addr   <= c_reset_pc;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid_i) begin
      // No issue happens in a redirect cycle, so nothing can be in flight next.
      r_fetch_pc <= redirect_pc_i;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + c_pc_step;  // wraps modulo 2^ADDR_W
        r_last_addr   <= r_fetch_pc;
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Instruction buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid_i) begin
      // Flush; any handshake this cycle has already completed at the outputs.
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= mem_data_i;
        r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_rw_en_o   = 1'b0;
  assign mem_data_o    = '0;
  assign mem_addr_o    = w_issue ? r_fetch_pc : r_last_addr;
  assign instr_valid_o = (r_count != 2'd0);
  assign instr_o       = r_fifo_data[r_rd_ptr];
  assign pc_o          = r_fifo_pc[r_rd_ptr];

`ifdef IF_PERF_CNT_EN
  // Completed decode handshakes, free-running modulo 2^32.
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_fetch_count <= 32'd0;
    end else if (w_pop) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count_o = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch                                               |
// | Description : Self-checking bench for instr_fetch with a queue-based        |
// |               reference model and a one-cycle-latency memory responder.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_fetch;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              areset_i;
  logic              enable_i;
  logic              redirect_valid_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              mem_rw_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic [DATA_W-1:0] instr_o;
  logic [ADDR_W-1:0] pc_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0]       fetch_count_o;
`endif

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(0)
  ) dut (
    .clk_i           (clk),
    .areset_i        (areset_i),
    .enable_i        (enable_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .mem_rw_en_o     (mem_rw_en_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .mem_data_i      (mem_data_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count_o   (fetch_count_o)
`endif
  );

  // Synchronous-read instruction memory: data for an address appears next cycle.
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) mem_data_i <= mem[mem_addr_o];

  // Reference model: a fetch pipe (addresses whose data returns next cycle)
  // and the instruction buffer as queues of word addresses.
  bit                m_run;
  logic [ADDR_W-1:0] m_fetch_pc;
  logic [ADDR_W-1:0] m_last_addr;
  logic [ADDR_W-1:0] m_fifo_pc [$];
  logic [ADDR_W-1:0] m_pipe    [$];
  int                m_hs;

  logic              exp_valid, obs_valid;
  logic [ADDR_W-1:0] exp_pc, obs_pc, exp_addr, obs_addr;
  logic [DATA_W-1:0] exp_instr, obs_instr;
  logic [ADDR_W-1:0] got_pcs [$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic string obs_s();
    return $sformatf("valid=%b pc=%h instr=%h addr=%h", obs_valid, obs_pc, obs_instr, obs_addr);
  endfunction

  function automatic string exp_s();
    return $sformatf("valid=%b pc=%h instr=%h addr=%h", exp_valid, exp_pc, exp_instr, exp_addr);
  endfunction

  task automatic model_reset();
    m_run       = 1'b0;
    m_fetch_pc  = '0;
    m_last_addr = '0;
    m_fifo_pc.delete();
    m_pipe.delete();
  endtask

  // Drive one cycle of inputs, predict and sample outputs, then advance model.
  task automatic run_cycle(input logic en, input logic rdy, input logic redir,
                           input logic [ADDR_W-1:0] rpc);
    logic pop;
    logic issue;
    int   occ;
    @(negedge clk);
    enable_i         = en;
    instr_ready_i    = rdy;
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    #4;
    exp_valid = (m_fifo_pc.size() != 0);
    exp_pc    = '0;
    exp_instr = '0;
    if (exp_valid) begin
      exp_pc    = m_fifo_pc[0];
      exp_instr = mem[m_fifo_pc[0]];
    end
    pop      = exp_valid && rdy;
    occ      = m_fifo_pc.size() + m_pipe.size() - (pop ? 1 : 0);
    issue    = !redir && m_run && (occ < 2);
    exp_addr = issue ? m_fetch_pc : m_last_addr;
    obs_valid = instr_valid_o;
    obs_pc    = (instr_valid_o === 1'b1) ? pc_o : '0;
    obs_instr = (instr_valid_o === 1'b1) ? instr_o : '0;
    obs_addr  = mem_addr_o;
    if (instr_valid_o === 1'b1 && rdy) got_pcs.push_back(pc_o);
    @(posedge clk);
    if (pop) begin
      void'(m_fifo_pc.pop_front());
      m_hs++;
    end
    if (redir) begin
      m_fifo_pc.delete();
      m_pipe.delete();
      m_fetch_pc = rpc;
    end else begin
      if (m_pipe.size() != 0) m_fifo_pc.push_back(m_pipe.pop_front());
      if (issue) begin
        m_pipe.push_back(m_fetch_pc);
        m_last_addr = m_fetch_pc;
        m_fetch_pc  = m_fetch_pc + 8'd1;
      end
    end
    m_run = en;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    areset_i = 1'b1; enable_i = 1'b0; redirect_valid_i = 1'b0; instr_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    areset_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    areset_i = 1'b1; enable_i = 1'b0; redirect_valid_i = 1'b0;
    redirect_pc_i = '0; instr_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    n_checks++; if (mem_addr_o !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", mem_addr_o); end
    n_checks++; if (mem_rw_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rw_en: got %b want 0", mem_rw_en_o); end
    n_checks++; if (mem_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_data_o); end
    n_checks++; if (pc_o !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc_o); end
    n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr_o); end
    areset_i = 1'b0;
    model_reset();
  endtask

  task automatic test_streaming();
    int first = -1;
    got_pcs.delete();
    for (int c = 0; c < 20; c++) begin
      run_cycle(1'b1, 1'b1, 1'b0, '0);
      n_checks++;
      if ({obs_valid, obs_pc, obs_instr, obs_addr} !== {exp_valid, exp_pc, exp_instr, exp_addr}) begin
        n_fail++; $display("FAIL stream cyc %0d: got %s want %s", c, obs_s(), exp_s());
      end
      if (first < 0 && obs_valid === 1'b1) first = c;
    end
    n_checks++; if (first != 3) begin n_fail++; $display("FAIL stream_latency: got %0d want 3", first); end
    n_checks++; if (got_pcs.size() != 17) begin n_fail++; $display("FAIL stream_count: got %0d want 17", got_pcs.size()); end
    for (int k = 0; k < got_pcs.size(); k++) begin
      n_checks++;
      if (got_pcs[k] !== 8'(k)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, got_pcs[k], 8'(k)); end
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    got_pcs.delete();
    hs0 = m_hs;
    for (int c = 0; c < 18; c++) begin
      run_cycle(1'b1, (c < 3 || c >= 8), 1'b0, '0);
      n_checks++;
      if ({obs_valid, obs_pc, obs_instr, obs_addr} !== {exp_valid, exp_pc, exp_instr, exp_addr}) begin
        n_fail++; $display("FAIL backpressure cyc %0d: got %s want %s", c, obs_s(), exp_s());
      end
    end
    n_checks++;
    if (got_pcs.size() != m_hs - hs0) begin
      n_fail++; $display("FAIL bp_count: got %0d want %0d", got_pcs.size(), m_hs - hs0);
    end
    for (int k = 1; k < got_pcs.size(); k++) begin
      n_checks++;
      if (got_pcs[k] !== got_pcs[k-1] + 8'd1) begin
        n_fail++; $display("FAIL bp_sequence[%0d]: got %h want %h", k, got_pcs[k], got_pcs[k-1] + 8'd1);
      end
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] want [4];
    want = '{8'd254, 8'd255, 8'd0, 8'd1};
    run_cycle(1'b1, 1'b1, 1'b1, 8'd254);
    got_pcs.delete();
    for (int c = 0; c < 7; c++) begin
      run_cycle(1'b1, 1'b1, 1'b0, '0);
      n_checks++;
      if ({obs_valid, obs_pc, obs_instr, obs_addr} !== {exp_valid, exp_pc, exp_instr, exp_addr}) begin
        n_fail++; $display("FAIL wrap cyc %0d: got %s want %s", c, obs_s(), exp_s());
      end
    end
    n_checks++;
    if (got_pcs.size() < 4) begin
      n_fail++; $display("FAIL wrap_count: got %0d want >=4", got_pcs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got_pcs[k] !== want[k]) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, got_pcs[k], want[k]); end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    logic [2:0]        vseen;
    logic [ADDR_W-1:0] addr1, pc3;
    for (int c = 0; c < 4; c++) run_cycle(1'b1, 1'b1, 1'b0, '0);
    run_cycle(1'b1, 1'b1, 1'b1, 8'h40);
    n_checks++;
    if ({obs_valid, obs_pc, obs_instr, obs_addr} !== {exp_valid, exp_pc, exp_instr, exp_addr}) begin
      n_fail++; $display("FAIL redirect cyc N: got %s want %s", obs_s(), exp_s());
    end
    vseen = '0; addr1 = '0; pc3 = '0;
    for (int c = 0; c < 3; c++) begin
      run_cycle(1'b1, 1'b1, 1'b0, '0);
      n_checks++;
      if ({obs_valid, obs_pc, obs_instr, obs_addr} !== {exp_valid, exp_pc, exp_instr, exp_addr}) begin
        n_fail++; $display("FAIL redirect cyc N+%0d: got %s want %s", c + 1, obs_s(), exp_s());
      end
      vseen[c] = obs_valid;
      if (c == 0) addr1 = obs_addr;
      if (c == 2) pc3 = obs_pc;
    end
    n_checks++; if (addr1 !== 8'h40) begin n_fail++; $display("FAIL redirect_issue_addr: got %h want 40", addr1); end
    n_checks++; if (vseen !== 3'b100) begin n_fail++; $display("FAIL redirect_valid_pattern: got %b want 100", vseen); end
    n_checks++; if (pc3 !== 8'h40) begin n_fail++; $display("FAIL redirect_first_pc: got %h want 40", pc3); end
  endtask

  task automatic test_idle_redirect();
    int                first = -1;
    logic [ADDR_W-1:0] first_pc = '0;
    logic [ADDR_W-1:0] addr1 = '0;
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b1, 1'b0, '0);
    run_cycle(1'b0, 1'b1, 1'b1, 8'h80);
    for (int c = 0; c < 2; c++) begin
      run_cycle(1'b0, 1'b1, 1'b0, '0);
      n_checks++;
      if (obs_valid !== 1'b0 || obs_addr !== exp_addr) begin
        n_fail++; $display("FAIL idle_hold cyc %0d: got %s want valid=0 addr=%h", c, obs_s(), exp_addr);
      end
    end
    for (int c = 0; c < 6; c++) begin
      run_cycle(1'b1, 1'b1, 1'b0, '0);
      n_checks++;
      if ({obs_valid, obs_pc, obs_instr, obs_addr} !== {exp_valid, exp_pc, exp_instr, exp_addr}) begin
        n_fail++; $display("FAIL idle_redirect cyc %0d: got %s want %s", c, obs_s(), exp_s());
      end
      if (c == 1) addr1 = obs_addr;
      if (first < 0 && obs_valid === 1'b1) begin first = c; first_pc = obs_pc; end
    end
    n_checks++; if (addr1 !== 8'h80) begin n_fail++; $display("FAIL idle_issue_addr: got %h want 80", addr1); end
    n_checks++; if (first != 3) begin n_fail++; $display("FAIL idle_latency: got %0d want 3", first); end
    n_checks++; if (first_pc !== 8'h80) begin n_fail++; $display("FAIL idle_first_pc: got %h want 80", first_pc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      run_cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 15) == 0), 8'($urandom));
      n_checks++;
      if ({obs_valid, obs_pc, obs_instr, obs_addr} !== {exp_valid, exp_pc, exp_instr, exp_addr}) begin
        n_fail++; $display("FAIL random cyc %0d: got %s want %s", c, obs_s(), exp_s());
      end
    end
  endtask

  task automatic test_reset_midstream();
    int                first = -1;
    logic [ADDR_W-1:0] first_pc = '1;
    for (int c = 0; c < 6; c++) run_cycle(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    areset_i = 1'b1; enable_i = 1'b0; redirect_valid_i = 1'b0;
    #1;
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", instr_valid_o); end
    n_checks++; if (mem_addr_o !== 8'h00) begin n_fail++; $display("FAIL midreset_addr: got %h want 00", mem_addr_o); end
    n_checks++; if (mem_rw_en_o !== 1'b0) begin n_fail++; $display("FAIL midreset_rw_en: got %b want 0", mem_rw_en_o); end
    @(posedge clk);
    @(negedge clk);
    areset_i = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      run_cycle(1'b1, 1'b1, 1'b0, '0);
      n_checks++;
      if ({obs_valid, obs_pc, obs_instr, obs_addr} !== {exp_valid, exp_pc, exp_instr, exp_addr}) begin
        n_fail++; $display("FAIL post_reset cyc %0d: got %s want %s", c, obs_s(), exp_s());
      end
      if (first < 0 && obs_valid === 1'b1) begin first = c; first_pc = obs_pc; end
    end
    n_checks++; if (first != 3) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 3", first); end
    n_checks++; if (first_pc !== 8'h00) begin n_fail++; $display("FAIL post_reset_pc: got %h want 00", first_pc); end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf_count();
    int guard = 0;
    apply_reset();
    got_pcs.delete();
    while (got_pcs.size() < 10 && guard < 40) begin
      run_cycle(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    n_checks++;
    if (got_pcs.size() != 10) begin
      n_fail++; $display("FAIL perf_handshakes: got %0d want 10", got_pcs.size());
    end
    run_cycle(1'b1, 1'b0, 1'b0, '0);
    #1;
    n_checks++;
    if (fetch_count_o !== 32'd10) begin n_fail++; $display("FAIL perf_count: got %0d want 10", fetch_count_o); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h01010101;
    m_hs = 0;
    model_reset();
    test_reset();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_redirect_inflight();
    test_idle_redirect();
    test_random();
    test_reset_midstream();
`ifdef IF_PERF_CNT_EN
    test_perf_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of instruction memory.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, fetch word address after reset.
REQ-004 SHALL have port clk_i  input  1  single clock; all state rises on posedge.
REQ-005 SHALL have port areset_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable_i  input  1  permit issuing new fetches.
REQ-007 SHALL have port redirect_valid_i  input  1  control-flow redirect request.
REQ-008 SHALL have port redirect_pc_i  input  ADDR_W  redirect target word address.
REQ-009 SHALL have port mem_rw_en_o  output  1  memory write enable, tied 0 (read-only).
REQ-010 SHALL have port mem_addr_o  output  ADDR_W  memory read address.
REQ-011 SHALL have port mem_data_o  output  DATA_W  memory write data, tied 0.
REQ-012 SHALL have port mem_data_i  input  DATA_W  memory read data, valid the cycle after the address.
REQ-013 SHALL have port instr_valid_o  output  1  instruction available to decode.
REQ-014 SHALL have port instr_ready_i  input  1  decode accepts instruction.
REQ-015 SHALL have port instr_o  output  DATA_W  fetched instruction.
REQ-016 SHALL have port pc_o  output  ADDR_W  word address of instr_o.

Function
REQ-017 SHALL implement FSM states IDLE and RUN; IDLE->RUN when enable_i=1, RUN->IDLE when enable_i=0.
REQ-018 SHALL issue a fetch in a RUN cycle only when occupancy + inflight - pop < 2 (pop = instr_valid_o & instr_ready_i); issue drives mem_addr_o = fetch_pc, sets inflight, increments fetch_pc.
REQ-019 SHALL hold mem_addr_o at the last issued address in non-issue cycles.
REQ-020 SHALL wrap fetch_pc modulo 2^ADDR_W (255 -> 0 at default).
REQ-021 SHALL capture mem_data_i with its issue address into a 2-entry FIFO the cycle after issue unless squashed.
REQ-022 SHALL drive instr_valid_o = FIFO not empty; instr_o/pc_o = FIFO head, stable while valid & !ready.
REQ-023 SHALL support push and pop in the same cycle; FIFO never overflows or duplicates.
REQ-024 SHALL sustain 1 instruction/cycle with instr_ready_i constantly 1.
REQ-025 SHALL give latency: enable_i high in cycle 0 from IDLE -> address issued cycle 1 -> instr_valid_o cycle 3.
REQ-026 SHALL, on redirect_valid_i in cycle N: complete any handshake in N, flush FIFO at end of N, squash response returning in N+1, set fetch_pc = redirect_pc_i; in RUN issue redirect_pc_i in N+1 and first valid in N+3.
REQ-027 SHALL, on redirect in IDLE, only load fetch_pc and flush; no issue until RUN.
REQ-028 SHALL give redirect priority over issue and push in the same cycle.
REQ-029 SHALL let an in-flight response complete normally when RUN->IDLE occurs.

Reset
REQ-030 SHALL, while areset_i=1, immediately force: state IDLE, fetch_pc=RESET_PC, mem_addr_o=RESET_PC, FIFO empty, inflight=0, instr_valid_o=0, instr_o=0, pc_o=0.
REQ-031 SHALL discard any in-flight response on reset mid-operation; first post-reset fetch is RESET_PC.

Configuration
REQ-032 SHALL, with IF_PERF_CNT_EN defined, add output fetch_count_o (32 bits) counting completed handshakes, reset 0, wrapping at 2^32.
REQ-033 SHALL, without IF_PERF_CNT_EN, omit fetch_count_o and its logic entirely.

Verification
REQ-034 SHALL check reset: areset_i=1 mid-stream -> instr_valid_o=0 same cycle, mem_addr_o=0, mem_rw_en_o=0.
REQ-035 SHALL check streaming: memory preloaded with mem[i]=i*0x01010101, ready=1 -> pc_o 0,1,2,... each cycle from cycle 3, instr_o matching.
REQ-036 SHALL check backpressure: instr_ready_i=0 for 5 cycles -> holds at 2 buffered, no issue, resumes with no loss/duplicate.
REQ-037 SHALL check wrap: redirect_pc_i=254 -> pc_o sequence 254,255,0,1.
REQ-038 SHALL check redirect with in-flight fetch: redirect to 0x40 -> next valid pc_o=0x40 three cycles later, no stale instruction.
REQ-039 SHALL check IF_PERF_CNT_EN build: 10 handshakes -> fetch_count_o=10.
